// File: rtl/mux_n1_stream_if.sv
// Bus bundle for mux_n1_stream: N input channels, one registered output channel.
// Optional O_XFER_COUNT exists only when MUX_XFER_COUNT_EN is defined.
interface mux_n1_stream_if #(
   parameter int WIDTH     = 16,
   parameter int CHANNELS  = 4,
   parameter int SEL_WIDTH = 2
);
   logic [CHANNELS*WIDTH-1:0] I_DATA;
   logic [CHANNELS-1:0]       I_VALID;
   logic [CHANNELS-1:0]       O_READY;
   logic                      I_MODE;
   logic [SEL_WIDTH-1:0]      I_SEL;
   logic [WIDTH-1:0]          O_DATA;
   logic                      O_VALID;
   logic                      I_READY;
   logic [SEL_WIDTH-1:0]      O_SEL;
`ifdef MUX_XFER_COUNT_EN
   logic [15:0]               O_XFER_COUNT;
`endif

   // master drives the mux inputs and consumes its output; slave is the mux itself
   modport master (
      output I_DATA, I_VALID, I_MODE, I_SEL, I_READY,
      input  O_READY, O_DATA, O_VALID, O_SEL
`ifdef MUX_XFER_COUNT_EN
      , input O_XFER_COUNT
`endif
   );

   modport slave (
      input  I_DATA, I_VALID, I_MODE, I_SEL, I_READY,
      output O_READY, O_DATA, O_VALID, O_SEL
`ifdef MUX_XFER_COUNT_EN
      , output O_XFER_COUNT
`endif
   );
endinterface

// File: rtl/mux_n1_stream.sv
// N-to-1 registered stream mux with fixed or round-robin channel select.
// Define MUX_XFER_COUNT_EN to add the 16-bit output handshake counter O_XFER_COUNT.
module mux_n1_stream #(
   parameter int WIDTH     = 16,
   parameter int CHANNELS  = 4,
   parameter int SEL_WIDTH = 2
) (
   input  logic             I_CLK,
   input  logic             I_RESET,
   mux_n1_stream_if.slave   bus
);
   localparam int                 IDXW   = SEL_WIDTH + 1;
   localparam logic [IDXW-1:0]    CH_W   = IDXW'(CHANNELS);
   localparam logic [IDXW-1:0]    LAST_W = IDXW'(CHANNELS - 1);

   // Handshake: a word moves on any channel in a cycle where its valid and ready are both 1;
   // the producer holds data stable while valid is high and ready is low.
   logic [WIDTH-1:0]     data_q, data_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d;
   logic                 valid_q, valid_d;
   logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

   logic                 accept;
   logic                 grant_vld;
   logic [SEL_WIDTH-1:0] grant;
   logic [IDXW-1:0]      idx;
   logic                 xfer;
   logic [CHANNELS-1:0]  ready;

   always_comb begin
      accept    = !valid_q || bus.I_READY;
      grant_vld = 1'b0;
      grant     = '0;
      idx       = '0;
      if (!bus.I_MODE) begin
         if ({1'b0, bus.I_SEL} < CH_W) begin
            grant     = bus.I_SEL;
            grant_vld = bus.I_VALID[bus.I_SEL];
         end
      end else begin
         // Search upward from the pointer; explicit wrap keeps non-power-of-two counts correct
         for (int i = 0; i < CHANNELS; i++) begin
            idx = {1'b0, ptr_q} + IDXW'(i);
            if (idx >= CH_W) idx = idx - CH_W;
            if (!grant_vld && bus.I_VALID[idx[SEL_WIDTH-1:0]]) begin
               grant_vld = 1'b1;
               grant     = idx[SEL_WIDTH-1:0];
            end
         end
      end
      xfer  = accept && grant_vld;
      ready = '0;
      if (xfer) ready[grant] = 1'b1;

      data_d  = data_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         data_d  = bus.I_DATA[grant*WIDTH +: WIDTH];
         sel_d   = grant;
         valid_d = 1'b1;
         if (bus.I_MODE) ptr_d = ({1'b0, grant} == LAST_W) ? '0 : grant + SEL_WIDTH'(1);
      end else if (bus.I_READY) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         data_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         data_q  <= data_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.O_READY = ready;
   assign bus.O_DATA  = data_q;
   assign bus.O_SEL   = sel_q;
   assign bus.O_VALID = valid_q;

`ifdef MUX_XFER_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (valid_q && bus.I_READY) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign bus.O_XFER_COUNT = cnt_q;
`endif
endmodule

// File: tb/tb_mux_n1_stream.sv
// Directed bench for mux_n1_stream: fixed select, sweep, round-robin, backpressure, reset.
// Counter checks run only when MUX_XFER_COUNT_EN is defined.
module tb_mux_n1_stream;
   localparam int W = 16;
   localparam int N = 4;
   localparam int S = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic [W-1:0] exp_q[$];

   mux_n1_stream_if #(.WIDTH(W), .CHANNELS(N), .SEL_WIDTH(S)) bus ();

   mux_n1_stream #(.WIDTH(W), .CHANNELS(N), .SEL_WIDTH(S)) dut (
      .I_CLK   (clk),
      .I_RESET (rst),
      .bus     (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_ch(input int c, input logic [W-1:0] val);
      bus.I_DATA[c*W +: W] = val;
   endtask

   task automatic load_default_data();
      for (int c = 0; c < N; c++) set_ch(c, 16'h1000 + W'(c));
   endtask

   // scoreboard comparison
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.I_DATA  = '0;
      bus.I_VALID = '0;
      bus.I_MODE  = 1'b0;
      bus.I_SEL   = '0;
      bus.I_READY = 1'b0;

      // reset state
      do_reset();
      #1;
      check("reset_valid", 32'(bus.O_VALID), 32'd0);
      check("reset_data",  32'(bus.O_DATA),  32'd0);
      check("reset_sel",   32'(bus.O_SEL),   32'd0);
      check("reset_ready", 32'(bus.O_READY), 32'd0);

      // fixed select of channel 2, all valid, sustained flow
      load_default_data();
      bus.I_SEL = 2'd2;
      bus.I_VALID = 4'b1111;
      bus.I_READY = 1'b1;
      #1;
      check("fix_ready0", 32'(bus.O_READY), 32'b0100);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("fix_data",  32'(bus.O_DATA),  32'h1002);
         check("fix_sel",   32'(bus.O_SEL),   32'd2);
         check("fix_valid", 32'(bus.O_VALID), 32'd1);
         check("fix_ready", 32'(bus.O_READY), 32'b0100);
      end

      // exhaustive select x valid sweep
      for (int s = 0; s < N; s++) begin
         for (int v = 0; v < 16; v++) begin
            bus.I_SEL   = S'(s);
            bus.I_VALID = 4'(v);
            #1;
            check("sweep_ready", 32'(bus.O_READY), ((v >> s) & 1) != 0 ? (32'd1 << s) : 32'd0);
            tick();
            if (((v >> s) & 1) != 0) begin
               check("sweep_data",  32'(bus.O_DATA),  32'h1000 + 32'(s));
               check("sweep_sel",   32'(bus.O_SEL),   32'(s));
               check("sweep_valid", 32'(bus.O_VALID), 32'd1);
            end else begin
               check("sweep_drain", 32'(bus.O_VALID), 32'd0);
            end
         end
      end

      // round-robin with all channels valid
      do_reset();
      bus.I_MODE  = 1'b1;
      bus.I_VALID = 4'b1111;
      bus.I_READY = 1'b1;
      exp_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
      while (exp_q.size() > 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         tick();
         check("rr_sel",  32'(bus.O_SEL),  32'(e));
         check("rr_data", 32'(bus.O_DATA), 32'h1000 + 32'(e));
      end

      // round-robin with channels 1 and 3 valid
      do_reset();
      bus.I_VALID = 4'b1010;
      exp_q = '{16'd1, 16'd3, 16'd1, 16'd3};
      while (exp_q.size() > 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         tick();
         check("rr2_sel",   32'(bus.O_SEL),   32'(e));
         check("rr2_valid", 32'(bus.O_VALID), 32'd1);
      end

      // backpressure: hold ABCD for 5 stalled cycles, then refill on release
      do_reset();
      bus.I_MODE  = 1'b0;
      bus.I_SEL   = 2'd0;
      bus.I_VALID = 4'b1111;
      bus.I_READY = 1'b1;
      set_ch(0, 16'hABCD);
      tick();
      check("bp_load", 32'(bus.O_DATA), 32'hABCD);
      bus.I_READY = 1'b0;
      set_ch(0, 16'h1234);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_ready", 32'(bus.O_READY), 32'd0);
         tick();
         check("bp_data",  32'(bus.O_DATA),  32'hABCD);
         check("bp_valid", 32'(bus.O_VALID), 32'd1);
      end
      bus.I_READY = 1'b1;
      #1;
      check("bp_release_ready", 32'(bus.O_READY), 32'b0001);
      tick();
      check("bp_refill", 32'(bus.O_DATA), 32'h1234);

      // reset mid-stream with pointer at 2
      load_default_data();
      do_reset();
      bus.I_MODE = 1'b1;
      tick();
      tick();
      check("mid_pre_sel", 32'(bus.O_SEL), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_valid", 32'(bus.O_VALID), 32'd0);
      check("mid_data",  32'(bus.O_DATA),  32'd0);
      check("mid_sel",   32'(bus.O_SEL),   32'd0);
      tick();
      check("mid_restart_sel",  32'(bus.O_SEL),  32'd0);
      check("mid_restart_data", 32'(bus.O_DATA), 32'h1000);

`ifdef MUX_XFER_COUNT_EN
      // 70001 loads give 70000 output handshakes
      do_reset();
      check("cnt_reset", 32'(bus.O_XFER_COUNT), 32'd0);
      bus.I_MODE  = 1'b0;
      bus.I_SEL   = 2'd0;
      bus.I_VALID = 4'b1111;
      bus.I_READY = 1'b1;
      repeat (70001) tick();
      bus.I_READY = 1'b0;
      check("cnt_wrap", 32'(bus.O_XFER_COUNT), 32'd4464);
      repeat (3) tick();
      check("cnt_stall", 32'(bus.O_XFER_COUNT), 32'd4464);
`endif

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
